// File: rtl/cic_pkg.sv
// Shared sizing helpers and limits for the CIC interpolator family.
package cic_pkg;

  localparam int CIC_MAX_N     = 6;
  localparam int CIC_MAX_RLOG2 = 6;

  // Internal width: input width plus bit growth of the R^(N-1) DC gain.
  function automatic int cic_iw(input int dw, input int n, input int rlog2);
    return dw + (n - 1) * rlog2;
  endfunction

  function automatic int cic_shift(input int n, input int rlog2);
    return (n - 1) * rlog2;
  endfunction

endpackage

// File: rtl/cic_integrator_stage.sv
// One high-rate CIC integrator: wrapping accumulator that advances only when enabled.
module cic_integrator_stage #(
  parameter int IW = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic signed [IW-1:0] din,
  output logic signed [IW-1:0] acc
);

  logic signed [IW-1:0] acc_q;
  logic signed [IW-1:0] acc_d;

  always_comb begin
    acc_d = acc_q;
    if (en) begin
      acc_d = acc_q + din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/cic_interpolator.sv
// CIC interpolator: N low-rate combs, zero-stuff by R, N high-rate integrators, 2^S gain removal.
// Define CIC_INTERP_ROUND_EN to round half-up before the gain shift instead of truncating.
module cic_interpolator
  import cic_pkg::*;
#(
  parameter int DW    = 16,
  parameter int N     = 3,
  parameter int RLOG2 = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce_in,
  output logic          ce_req,
  input  logic [DW-1:0] sig_in,
  output logic          ce_out,
  output logic [DW-1:0] sig_out
);

  localparam int IW = cic_iw(DW, N, RLOG2);
  localparam int S  = cic_shift(N, RLOG2);
  localparam int PW = (RLOG2 > 0) ? RLOG2 : 1;

  // ---------------- phase counter ----------------
  logic [PW-1:0] phase_q;
  logic [PW-1:0] phase_d;
  logic          phase_zero;

  assign phase_zero = (phase_q == '0);
  assign ce_req     = ce_in && phase_zero;

  always_comb begin
    phase_d = phase_q;
    if (ce_in) begin
      // R = 2^RLOG2, so the natural PW-bit wrap is the R-1 -> 0 wrap.
      if (RLOG2 == 0) begin
        phase_d = '0;
      end else begin
        phase_d = phase_q + PW'(1);
      end
    end
  end

  // ---------------- comb section (low rate) ----------------
  logic signed [DW-1:0] sig_in_s;
  logic signed [IW-1:0] comb_c [N+1];
  logic signed [IW-1:0] d_q    [N];
  logic signed [IW-1:0] d_d    [N];
  logic signed [IW-1:0] comb_q;
  logic signed [IW-1:0] comb_d;

  assign sig_in_s  = sig_in;
  assign comb_c[0] = IW'(sig_in_s);

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_comb
      assign comb_c[gi+1] = comb_c[gi] - d_q[gi];
    end
  endgenerate

  always_comb begin
    d_d    = d_q;
    comb_d = comb_q;
    if (ce_req) begin
      for (int i = 0; i < N; i++) begin
        d_d[i] = comb_c[i];
      end
      comb_d = comb_c[N];
    end
  end

  // ---------------- zero-stuff upsampler ----------------
  logic signed [IW-1:0] up;
  assign up = phase_zero ? comb_q : '0;

  // ---------------- integrators (high rate) ----------------
  logic signed [IW-1:0] integ [N];

  generate
    for (gi = 0; gi < N; gi++) begin : g_integ
      logic signed [IW-1:0] stage_in;
      if (gi == 0) begin : g_first
        assign stage_in = up;
      end else begin : g_chain
        assign stage_in = integ[gi-1];
      end
      cic_integrator_stage #(
        .IW(IW)
      ) u_stage (
        .clk (clk),
        .rst (rst),
        .en  (ce_in),
        .din (stage_in),
        .acc (integ[gi])
      );
    end
  endgenerate

  // ---------------- gain normalisation and output ----------------
`ifdef CIC_INTERP_ROUND_EN
  localparam int                   RND_SH = (S > 0) ? S - 1 : 0;
  localparam logic signed [IW-1:0] RND    = (S > 0) ? (IW'(1) << RND_SH) : IW'(0);
`else
  localparam logic signed [IW-1:0] RND    = '0;
`endif

  logic signed [IW-1:0] out_pre;
  logic [DW-1:0]        sig_out_q;
  logic [DW-1:0]        sig_out_d;
  logic                 ce_out_q;
  logic                 ce_out_d;

  assign out_pre = integ[N-1] + RND;

  always_comb begin
    sig_out_d = sig_out_q;
    ce_out_d  = ce_in;
    if (ce_in) begin
      sig_out_d = DW'(out_pre >>> S);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q   <= '0;
      comb_q    <= '0;
      sig_out_q <= '0;
      ce_out_q  <= 1'b0;
      for (int i = 0; i < N; i++) begin
        d_q[i] <= '0;
      end
    end else begin
      phase_q   <= phase_d;
      comb_q    <= comb_d;
      sig_out_q <= sig_out_d;
      ce_out_q  <= ce_out_d;
      d_q       <= d_d;
    end
  end

  assign sig_out = sig_out_q;
  assign ce_out  = ce_out_q;

endmodule
